// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between alu_16bit, the result buffer and its consumer.
// The buffer uses the slave view; the environment driving it uses the master view.
interface alu_result_buffer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_f;
    logic             in_cout;
    logic [3:0]       in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_f;
    logic             out_c;
    logic             out_z;
    logic             out_n;
    logic [3:0]       out_tag;

    modport master (
        output in_valid, in_f, in_cout, in_tag, out_ready,
        input  in_ready, out_valid, out_f, out_c, out_z, out_n, out_tag
    );

    modport slave (
        input  in_valid, in_f, in_cout, in_tag, out_ready,
        output in_ready, out_valid, out_f, out_c, out_z, out_n, out_tag
    );
endinterface

// File: rtl/alu_result_buffer.sv
// FWFT result FIFO behind alu_16bit: flags computed at capture, accumulator
// copy of the last accepted result fed back for chained operations.
module alu_result_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_result_buffer_if.slave    bus,
    output logic [WIDTH-1:0]      acc_q,
    output logic [2:0]            flags_q,
    output logic [AW:0]           count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] acc_d;
    logic [2:0]       flags_d;

    logic [WIDTH-1:0] f_mem   [DEPTH];
    logic [3:0]       tag_mem [DEPTH];
    logic [2:0]       cnz_mem [DEPTH];

    logic             push;
    logic             pop;
    logic [2:0]       in_cnz;

    // in_ready looks at out_ready so a full buffer can accept while draining.
    always_comb begin
        in_cnz        = {bus.in_cout, bus.in_f[WIDTH-1], (bus.in_f == '0)};
        bus.in_ready  = (count_q != FULL) || bus.out_ready;
        bus.out_valid = (count_q != '0);
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        acc_d   = push ? bus.in_f : acc_q;
        flags_d = push ? in_cnz   : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_mem[wr_ptr_q]   <= bus.in_f;
            tag_mem[wr_ptr_q] <= bus.in_tag;
            cnz_mem[wr_ptr_q] <= in_cnz;
        end
    end

    always_comb begin
        bus.out_f   = '0;
        bus.out_c   = 1'b0;
        bus.out_n   = 1'b0;
        bus.out_z   = 1'b0;
        bus.out_tag = '0;
        if (bus.out_valid) begin
            bus.out_f                         = f_mem[rd_ptr_q];
            {bus.out_c, bus.out_n, bus.out_z} = cnz_mem[rd_ptr_q];
            bus.out_tag                       = tag_mem[rd_ptr_q];
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Bench for alu_result_buffer: directed vector table, reset/stream sequences,
// then random traffic against a queue-based reference model.
module tb_alu_result_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0] acc_q;
    logic [2:0]       flags_q;
    logic [AW:0]      count;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .acc_q   (acc_q),
        .flags_q (flags_q),
        .count   (count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v, r;
        logic [15:0] f;
        logic        c;
        logic [3:0]  t;
        logic        rdy;
        logic [2:0]  cnt;
        logic [15:0] of;
        logic        oc, oz, on;
        logic [3:0]  ot;
        logic [15:0] acc;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [15:0] f;
        logic        c, n, z;
        logic [3:0]  t;
    } entry_t;

    vec_t   tbl [18];
    entry_t q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string nm, input logic [2:0] cnt, input logic [15:0] f,
                              input logic c, input logic z, input logic n, input logic [3:0] t,
                              input logic [15:0] acc, input logic [2:0] flg);
        check({nm, "_count"}, 32'(count), 32'(cnt));
        check({nm, "_ovalid"}, 32'(bus.out_valid), 32'(cnt != 0));
        check({nm, "_head"}, {8'h0, bus.out_f, bus.out_c, bus.out_z, bus.out_n, 1'b0, bus.out_tag},
              {8'h0, f, c, z, n, 1'b0, t});
        check({nm, "_acc_flags"}, {13'h0, acc_q, flags_q}, {13'h0, acc, flg});
    endtask

    task automatic drive(input logic v, input logic r, input logic [15:0] f, input logic c,
                         input logic [3:0] t);
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_f      = f;
        bus.in_cout   = c;
        bus.in_tag    = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic v, logic r, logic [15:0] f, logic c, logic [3:0] t,
                                logic rdy, logic [2:0] cnt, logic [15:0] of, logic oc,
                                logic oz, logic on, logic [3:0] ot, logic [15:0] acc,
                                logic [2:0] flg);
        vec_t x;
        x.v = v; x.r = r; x.f = f; x.c = c; x.t = t; x.rdy = rdy; x.cnt = cnt;
        x.of = of; x.oc = oc; x.oz = oz; x.on = on; x.ot = ot; x.acc = acc; x.flg = flg;
        return x;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        v, r, c, push, pop, hold;
        logic [15:0] f, m_acc;
        logic [3:0]  t;
        logic [2:0]  m_flg;
        entry_t      e;

        //            v  r  f        c  t   rdy cnt of       oc oz on ot  acc      flg
        tbl[0]  = mk(1, 1, 16'h0003, 0, 1,  1, 1, 16'h0003, 0, 0, 0, 1, 16'h0003, 3'b000);
        tbl[1]  = mk(0, 1, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 16'h0003, 3'b000);
        tbl[2]  = mk(1, 0, 16'h0000, 1, 2,  1, 1, 16'h0000, 1, 1, 0, 2, 16'h0000, 3'b101);
        tbl[3]  = mk(1, 0, 16'h8001, 0, 3,  1, 2, 16'h0000, 1, 1, 0, 2, 16'h8001, 3'b010);
        tbl[4]  = mk(0, 1, 16'h0000, 0, 0,  1, 1, 16'h8001, 0, 0, 1, 3, 16'h8001, 3'b010);
        tbl[5]  = mk(0, 1, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 16'h8001, 3'b010);
        tbl[6]  = mk(1, 0, 16'h0001, 0, 4,  1, 1, 16'h0001, 0, 0, 0, 4, 16'h0001, 3'b000);
        tbl[7]  = mk(1, 0, 16'h0002, 0, 5,  1, 2, 16'h0001, 0, 0, 0, 4, 16'h0002, 3'b000);
        tbl[8]  = mk(1, 0, 16'h0003, 0, 6,  1, 3, 16'h0001, 0, 0, 0, 4, 16'h0003, 3'b000);
        tbl[9]  = mk(1, 0, 16'h0004, 0, 7,  1, 4, 16'h0001, 0, 0, 0, 4, 16'h0004, 3'b000);
        tbl[10] = mk(1, 0, 16'h0005, 0, 8,  0, 4, 16'h0001, 0, 0, 0, 4, 16'h0004, 3'b000);
        tbl[11] = mk(1, 1, 16'h00AA, 0, 9,  1, 4, 16'h0002, 0, 0, 0, 5, 16'h00AA, 3'b000);
        tbl[12] = mk(0, 1, 16'h0000, 0, 0,  1, 3, 16'h0003, 0, 0, 0, 6, 16'h00AA, 3'b000);
        tbl[13] = mk(0, 1, 16'h0000, 0, 0,  1, 2, 16'h0004, 0, 0, 0, 7, 16'h00AA, 3'b000);
        tbl[14] = mk(0, 1, 16'h0000, 0, 0,  1, 1, 16'h00AA, 0, 0, 0, 9, 16'h00AA, 3'b000);
        tbl[15] = mk(0, 1, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 16'h00AA, 3'b000);
        tbl[16] = mk(1, 0, 16'hFFFF, 1, 15, 1, 1, 16'hFFFF, 1, 0, 1, 15, 16'hFFFF, 3'b110);
        tbl[17] = mk(0, 1, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 3'b110);

        drive(0, 0, 16'h0, 0, 4'h0);
        #2 rst = 1'b1;
        #1 check_head("por", 0, 16'h0, 0, 0, 0, 4'h0, 16'h0, 3'b000);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].c, tbl[i].t);
            #1 check($sformatf("tbl%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            step();
            check_head($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].of, tbl[i].oc, tbl[i].oz,
                       tbl[i].on, tbl[i].ot, tbl[i].acc, tbl[i].flg);
        end

        // Asynchronous reset with two entries stored, checked before the next edge.
        drive(1, 0, 16'h0011, 0, 4'h1); step();
        drive(1, 0, 16'h0022, 0, 4'h2); step();
        check("pre_arst_count", 32'(count), 32'd2);
        drive(1, 0, 16'h0055, 1, 4'h5);
        #2 rst = 1'b1;
        #1 check_head("arst", 0, 16'h0, 0, 0, 0, 4'h0, 16'h0, 3'b000);
        step();
        check_head("arst_held", 0, 16'h0, 0, 0, 0, 4'h0, 16'h0, 3'b000);
        #2 rst = 1'b0;
        step();
        check_head("post_arst", 1, 16'h0055, 1, 0, 0, 4'h5, 16'h0055, 3'b100);
        drive(0, 1, 16'h0, 0, 4'h0); step();
        check("post_arst_drain", 32'(count), 32'd0);

        // Back-to-back streaming: each value appears one cycle after its push.
        for (int n = 0; n < 10; n++) begin
            drive(1, 1, 16'(n), 0, 4'(n));
            #1 check($sformatf("stream%0d_in_ready", n), 32'(bus.in_ready), 32'd1);
            step();
            check_head($sformatf("stream%0d", n), 1, 16'(n), 0, (n == 0), 0, 4'(n),
                       16'(n), {2'b00, (n == 0)});
        end
        drive(0, 1, 16'h0, 0, 4'h0); step();
        check("stream_drain", 32'(count), 32'd0);

        m_acc = 16'd9;
        m_flg = 3'b000;
        hold  = 1'b0;
        v = 0; f = '0; c = 0; t = '0;
        for (int k = 0; k < 400; k++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       f = 16'h0000;
                    1:       f = 16'h8000 | 16'($urandom);
                    default: f = 16'($urandom);
                endcase
                c = 1'($urandom);
                t = 4'($urandom);
            end
            r = (k % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            drive(v, r, f, c, t);
            push = v && ((q.size() < DEPTH) || r);
            pop  = r && (q.size() > 0);
            #1 check("rnd_in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) || r));
            step();
            if (pop) void'(q.pop_front());
            if (push) begin
                e.f = f; e.c = c; e.n = f[15]; e.z = (f == 16'h0000); e.t = t;
                q.push_back(e);
                m_acc = f;
                m_flg = {e.c, e.n, e.z};
            end
            hold = v && !push;
            if (q.size() > 0)
                check_head("rnd", 3'(q.size()), q[0].f, q[0].c, q[0].z, q[0].n, q[0].t, m_acc, m_flg);
            else
                check_head("rnd", 3'd0, 16'h0, 0, 0, 0, 4'h0, m_acc, m_flg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream consumer of alu_16bit. Captures each ALU result (f, cout) with a destination tag.
- Computes status flags on capture and holds results in a small first-word-fall-through FIFO with valid/ready on both sides.
- Keeps an accumulator copy of the last accepted result, fed back to the ALU "a" operand mux for chained operations.

Parameters:
- WIDTH, 16, datapath width; matches alu_16bit f.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a result this cycle.
- in_ready  output  1  buffer can accept this cycle.
- in_f  input  WIDTH  ALU result f.
- in_cout  input  1  ALU carry out (Cn+4).
- in_tag  input  4  destination/operation tag travelling with the result.
- out_valid  output  1  head entry present.
- out_ready  input  1  downstream takes head this cycle.
- out_f  output  WIDTH  head result.
- out_c  output  1  head carry flag.
- out_z  output  1  head zero flag.
- out_n  output  1  head negative flag.
- out_tag  output  4  head tag.
- acc_q  output  WIDTH  last accepted in_f.
- flags_q  output  3  {C,N,Z} of last accepted result.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, independent of clk.
  - Reset clears: wr_ptr, rd_ptr, count, acc_q, flags_q; out_valid=0.
  - All buffered entries are discarded. Storage contents need not be cleared.
- Reset asserted mid-transfer: the in-flight push or pop is lost. First acceptance is on the first rising edge after rst deasserts.
- Push when in_valid && in_ready at a rising edge.
  - Store {tag, C=in_cout, N=in_f[WIDTH-1], Z=(in_f==0), f} at wr_ptr.
  - wr_ptr increments modulo DEPTH; natural wrap, no gap.
  - Flags are computed at push time, not on the read side.
- Pop when out_valid && out_ready at a rising edge: rd_ptr increments modulo DEPTH.
- out_valid = (count != 0).
- out_f/out_c/out_z/out_n/out_tag come combinationally from the entry at rd_ptr (first-word fall-through). All are forced to 0 when count==0.
- in_ready = (count < DEPTH) || out_ready.
  - When full, a simultaneous pop frees the slot in the same cycle.
  - in_ready therefore depends combinationally on out_ready. Downstream must not make out_ready depend on in_ready.
- count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Simultaneous push and pop with count==0 is impossible, since out_valid=0. Push only; count becomes 1.
- Simultaneous push and pop with count==DEPTH: both occur; count stays DEPTH, both pointers advance.
- Latency: a result pushed at edge k appears on out_* during cycle k+1 if the buffer was empty. Otherwise it appears after all older entries pop. Strict FIFO order.
- acc_q and flags_q load at every push edge with the pushed f and its {C,N,Z}. They hold otherwise and are unaffected by pops.
- in_valid while in_ready=0: nothing stored, all state holds. Upstream must hold in_f/in_cout/in_tag stable until accepted.
- No X propagation: while in_valid=0, in_f content is ignored.

Test Plan:
- Reset: assert rst asynchronously between edges with 2 entries stored -> count=0, out_valid=0, out_f=0, acc_q=0, flags_q=000 immediately, before the next clk edge.
- Single pass, out_ready=1:
  - Push f=16'h0003, cout=0, tag=1 -> next cycle out_valid=1, out_f=16'h0003, out_z=0, out_n=0, out_c=0, out_tag=1.
  - acc_q=16'h0003.
  - Popped at the following edge; count returns to 0.
- Flags: push 16'h0000 cout=1, then 16'h8001 cout=0, with out_ready=0:
  - Head shows Z=1, C=1, N=0.
  - After one pop, head shows N=1, Z=0, C=0.
  - flags_q=3'b010 after the second push.
- Fill and wrap, out_ready=0:
  - Push 16'h0001..16'h0004 -> count=4, in_ready=0.
  - 5th in_valid with 16'h0005 is not accepted; acc_q stays 16'h0004.
  - Raise out_ready -> pops 1,2,3,4 in order; pointers wrap to 0.
- Full with simultaneous push/pop:
  - At count=4, in_valid=1 (16'h00AA) and out_ready=1 in one cycle -> 16'h0001 leaves, 16'h00AA enters, count stays 4.
  - Later drain ends with 16'h00AA.
- Back-to-back streaming, in_valid=1 and out_ready=1 for 10 cycles with in_f=n -> count stays ≤1, outputs 0..9 each one cycle after push, no drops or duplicates.
